// File: rtl/spi_adc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_adc_pkg
// Description : Shared FSM state encoding and address-width helper for the
//               SPI ADC channel scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_adc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CS_SETUP = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_CS_HOLD  = 3'd3,
        ST_GAP      = 3'd4
    } state_e;

    // A single-channel scanner still carries a one-bit (always zero) address.
    function automatic int addr_w_f(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : spi_tick_gen
// Description : SCK half-period timer; pulses tick_o every CLK_DIV enabled
//               cycles and restarts from zero whenever the scanner changes state.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam int               CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!en_i || restart_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_adc_scanner.sv
`default_nettype none
// ============================================================================
// Module      : spi_adc_scanner
// Description : SPI mode-0 master that scans the enabled ADC channels, one
//               CS-low frame per channel, and reports each captured result.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_adc_scanner
    import spi_adc_pkg::*;
#(
    parameter  int DATA_W     = 12,
    parameter  int N_CH       = 4,
    parameter  int FRAME_BITS = 16,
    parameter  int CLK_DIV    = 4,
    localparam int ADDR_W     = addr_w_f(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cont,
    input  logic [N_CH-1:0]   ch_mask,
    input  logic              MISO,
    output logic              MOSI,
    output logic              SCK,
    output logic              CS,
    output logic [DATA_W-1:0] ch_data,
    output logic [ADDR_W-1:0] ch_idx,
    output logic              data_valid,
    output logic              scan_done,
    output logic              busy
);

    localparam int               BIT_W   = $clog2(FRAME_BITS);
    localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(FRAME_BITS - 1);

    generate
        if (FRAME_BITS < DATA_W + ADDR_W) begin : g_frame_check
            $error("FRAME_BITS cannot hold the channel address plus the result");
        end
        if (CLK_DIV < 1) begin : g_div_check
            $error("CLK_DIV must be at least 1");
        end
    endgenerate

    state_e                state_q, state_d;
    logic [N_CH-1:0]       mask_q, mask_d;
    logic [ADDR_W-1:0]     ch_q, ch_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic                  sck_q, sck_d;
    logic                  cs_q, cs_d;
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [DATA_W-1:0]     rx_q, rx_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [ADDR_W-1:0]     idx_q, idx_d;
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;

    logic                  tick;
    logic [ADDR_W-1:0]     first_ch;
    logic [ADDR_W-1:0]     next_ch;
    logic                  next_found;

    function automatic logic [FRAME_BITS-1:0] frame_of(input logic [ADDR_W-1:0] ch);
        logic [FRAME_BITS-1:0] f;
        f = '0;
        f[FRAME_BITS-1 -: ADDR_W] = ch;
        return f;
    endfunction

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (state_q != ST_IDLE),
        .restart_i (state_d != state_q),
        .tick_o    (tick)
    );

    // Lowest enabled channel of the live mask (used when a scan (re)starts).
    always_comb begin
        first_ch = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) first_ch = ADDR_W'(i);
        end
    end

    // Next enabled channel above the current one, from the latched mask.
    always_comb begin
        next_ch    = '0;
        next_found = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(ch_q))) begin
                next_ch    = ADDR_W'(i);
                next_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        ch_d    = ch_q;
        bit_d   = bit_q;
        sck_d   = sck_q;
        cs_d    = cs_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        data_d  = data_q;
        idx_d   = idx_q;
        valid_d = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && (|ch_mask)) begin
                    mask_d  = ch_mask;
                    ch_d    = first_ch;
                    tx_d    = frame_of(first_ch);
                    bit_d   = BIT_MAX;
                    cs_d    = 1'b0;
                    state_d = ST_CS_SETUP;
                end
            end
            ST_CS_SETUP: begin
                if (tick) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (!sck_q) begin
                        sck_d = 1'b1;
                        rx_d  = (rx_q << 1) | DATA_W'(MISO);
                    end else begin
                        sck_d = 1'b0;
                        if (bit_q == '0) begin
                            state_d = ST_CS_HOLD;
                        end else begin
                            bit_d = bit_q - BIT_W'(1);
                            tx_d  = tx_q << 1;
                        end
                    end
                end
            end
            ST_CS_HOLD: begin
                if (tick) begin
                    cs_d    = 1'b1;
                    data_d  = rx_q;
                    idx_d   = ch_q;
                    valid_d = 1'b1;
                    done_d  = !next_found;
                    tx_d    = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (next_found) begin
                        ch_d    = next_ch;
                        tx_d    = frame_of(next_ch);
                        bit_d   = BIT_MAX;
                        cs_d    = 1'b0;
                        state_d = ST_CS_SETUP;
                    end else if (cont && (|ch_mask)) begin
                        mask_d  = ch_mask;
                        ch_d    = first_ch;
                        tx_d    = frame_of(first_ch);
                        bit_d   = BIT_MAX;
                        cs_d    = 1'b0;
                        state_d = ST_CS_SETUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            ch_q    <= '0;
            bit_q   <= '0;
            sck_q   <= 1'b0;
            cs_q    <= 1'b1;
            tx_q    <= '0;
            rx_q    <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            ch_q    <= ch_d;
            bit_q   <= bit_d;
            sck_q   <= sck_d;
            cs_q    <= cs_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign MOSI       = tx_q[FRAME_BITS-1];
    assign SCK        = sck_q;
    assign CS         = cs_q;
    assign ch_data    = data_q;
    assign ch_idx     = idx_q;
    assign data_valid = valid_q;
    assign scan_done  = done_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_adc_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_adc_scanner
// Description : Directed bench for spi_adc_scanner with an address-decoding
//               ADC model on a default instance and a narrow fast instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_adc_scanner;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(negedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- instance A: defaults ----------------
    logic        a_start, a_cont, a_miso, a_mosi, a_sck, a_cs, a_valid, a_done, a_busy;
    logic [3:0]  a_mask;
    logic [11:0] a_data;
    logic [1:0]  a_idx;

    spi_adc_scanner dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .cont(a_cont), .ch_mask(a_mask),
        .MISO(a_miso), .MOSI(a_mosi), .SCK(a_sck), .CS(a_cs), .ch_data(a_data),
        .ch_idx(a_idx), .data_valid(a_valid), .scan_done(a_done), .busy(a_busy)
    );

    logic [11:0] a_val [4];
    logic [15:0] a_sr = '0, a_word = '0;
    logic [1:0]  a_addr = '0;
    int a_bitn = 0, a_falls = 0, a_fall_cyc = 0, a_period = 0, a_valids = 0;

    // ADC answers 4 leading ones (to be discarded) then the addressed result.
    function automatic logic resp_a(input int k);
        if (k < 4)   return 1'b1;
        if (k >= 16) return 1'b0;
        return a_val[a_addr][11 - (k - 4)];
    endfunction

    always @(negedge a_cs) begin
        a_bitn = 0; a_sr = '0; a_falls++;
        a_period = cyc - a_fall_cyc; a_fall_cyc = cyc;
        a_miso = resp_a(0);
    end
    always @(posedge a_sck) if (!a_cs) begin
        a_sr = {a_sr[14:0], a_mosi}; a_bitn++;
        if (a_bitn == 2) a_addr = a_sr[1:0];
    end
    always @(negedge a_sck) if (!a_cs) a_miso = resp_a(a_bitn);
    always @(posedge a_cs) a_word = a_sr;
    always @(negedge clk) if (a_valid) a_valids++;

    // ---------------- instance B: 10-bit, 8 channels, CLK_DIV=1 ----------------
    logic        b_start, b_cont, b_miso, b_mosi, b_sck, b_cs, b_valid, b_done, b_busy;
    logic [7:0]  b_mask;
    logic [9:0]  b_data;
    logic [2:0]  b_idx;

    spi_adc_scanner #(.DATA_W(10), .N_CH(8), .FRAME_BITS(16), .CLK_DIV(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .cont(b_cont), .ch_mask(b_mask),
        .MISO(b_miso), .MOSI(b_mosi), .SCK(b_sck), .CS(b_cs), .ch_data(b_data),
        .ch_idx(b_idx), .data_valid(b_valid), .scan_done(b_done), .busy(b_busy)
    );

    logic [9:0]  b_val [8];
    logic [15:0] b_sr = '0, b_word = '0;
    logic [2:0]  b_addr = '0;
    int b_bitn = 0, b_fall_cyc = 0, b_period = 0;

    function automatic logic resp_b(input int k);
        if (k < 6)   return 1'b1;
        if (k >= 16) return 1'b0;
        return b_val[b_addr][9 - (k - 6)];
    endfunction

    always @(negedge b_cs) begin
        b_bitn = 0; b_sr = '0;
        b_period = cyc - b_fall_cyc; b_fall_cyc = cyc;
        b_miso = resp_b(0);
    end
    always @(posedge b_sck) if (!b_cs) begin
        b_sr = {b_sr[14:0], b_mosi}; b_bitn++;
        if (b_bitn == 3) b_addr = b_sr[2:0];
    end
    always @(negedge b_sck) if (!b_cs) b_miso = resp_b(b_bitn);
    always @(posedge b_cs) b_word = b_sr;

    // ---------------- helpers ----------------
    task automatic wait_valid_a(input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk);
            if (a_valid) ok = 1'b1;
        end
    endtask

    task automatic wait_valid_b(input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk);
            if (b_valid) ok = 1'b1;
        end
    endtask

    task automatic wait_idle_a();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 500 && !ok; n++) begin
            @(negedge clk);
            if (!a_busy) ok = 1'b1;
        end
        chk("idle_reached", ok, 1);
    endtask

    task automatic start_a(input logic [3:0] m);
        @(negedge clk);
        a_mask  = m;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        chk("cs_low_after_start", a_cs, 0);
        chk("busy_after_start", a_busy, 1);
    endtask

    typedef struct {
        logic        new_scan;
        logic [3:0]  mask;
        logic [1:0]  idx;
        logic [11:0] data;
        logic [15:0] mosi;
        logic        done;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int v0, f0;

        a_val[0] = 12'hA5C; a_val[1] = 12'h5A3; a_val[2] = 12'h3F1; a_val[3] = 12'h801;
        for (int i = 0; i < 8; i++) b_val[i] = 10'h000;
        b_val[5] = 10'h2B7; b_val[7] = 10'h155;

        tbl[0] = '{1'b1, 4'b0101, 2'd0, 12'hA5C, 16'h0000, 1'b0};
        tbl[1] = '{1'b0, 4'b0101, 2'd2, 12'h3F1, 16'h8000, 1'b1};
        tbl[2] = '{1'b1, 4'b1111, 2'd0, 12'hA5C, 16'h0000, 1'b0};
        tbl[3] = '{1'b0, 4'b1111, 2'd1, 12'h5A3, 16'h4000, 1'b0};
        tbl[4] = '{1'b0, 4'b1111, 2'd2, 12'h3F1, 16'h8000, 1'b0};
        tbl[5] = '{1'b0, 4'b1111, 2'd3, 12'h801, 16'hC000, 1'b1};
        tbl[6] = '{1'b1, 4'b1000, 2'd3, 12'h801, 16'hC000, 1'b1};
        tbl[7] = '{1'b1, 4'b0110, 2'd1, 12'h5A3, 16'h4000, 1'b0};
        tbl[8] = '{1'b0, 4'b0110, 2'd2, 12'h3F1, 16'h8000, 1'b1};

        rst_n = 1'b0;
        a_start = 0; a_cont = 0; a_mask = '0;
        b_start = 0; b_cont = 0; b_mask = '0;
        repeat (3) @(negedge clk);
        chk("rst_cs", a_cs, 1);
        chk("rst_sck", a_sck, 0);
        chk("rst_mosi", a_mosi, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_data", a_data, 0);
        chk("rst_idx", a_idx, 0);
        chk("rst_valid", a_valid, 0);
        chk("rst_cs_b", b_cs, 1);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_quiet_cs", a_cs, 1);
        chk("post_rst_quiet_busy", a_busy, 0);

        // Table: each row is one frame; masks are scrambled after start.
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].new_scan) begin
                wait_idle_a();
                start_a(tbl[i].mask);
                a_mask = ~tbl[i].mask;
            end
            wait_valid_a(400, ok);
            chk("valid_seen", ok, 1);
            chk("ch_idx", a_idx, tbl[i].idx);
            chk("ch_data", a_data, tbl[i].data);
            chk("scan_done", a_done, tbl[i].done);
            chk("mosi_frame", a_word, tbl[i].mosi);
            if (!tbl[i].new_scan) chk("frame_period", a_period, 140);
            if (tbl[i].done) begin
                repeat (6) @(negedge clk);
                chk("busy_end", a_busy, 0);
                chk("data_hold", a_data, tbl[i].data);
                chk("cs_idle", a_cs, 1);
            end
        end

        // Start with an empty mask must not launch anything.
        wait_idle_a();
        f0 = a_falls;
        @(negedge clk); a_mask = 4'b0000; a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        repeat (10) @(negedge clk);
        chk("mask0_busy", a_busy, 0);
        chk("mask0_no_frame", a_falls, f0);

        // Start while busy is ignored.
        v0 = a_valids;
        start_a(4'b0001);
        repeat (50) @(negedge clk);
        a_mask = 4'b1111; a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        wait_valid_a(400, ok);
        chk("busy_start_valid", ok, 1);
        chk("busy_start_idx", a_idx, 0);
        repeat (300) @(negedge clk);
        chk("busy_start_one_frame", a_valids, v0 + 1);
        chk("busy_start_idle", a_busy, 0);

        // Continuous mode, mask relatched between scans, cont dropped mid-frame.
        a_cont = 1'b1;
        start_a(4'b1000);
        wait_valid_a(400, ok);
        chk("cont1_valid", ok, 1);
        chk("cont1_idx", a_idx, 3);
        chk("cont1_data", a_data, 12'h801);
        chk("cont1_done", a_done, 1);
        a_mask = 4'b0010;
        wait_valid_a(400, ok);
        chk("cont2_valid", ok, 1);
        chk("cont2_idx", a_idx, 1);
        chk("cont2_data", a_data, 12'h5A3);
        chk("cont2_mosi", a_word, 16'h4000);
        chk("cont2_period", a_period, 140);
        repeat (20) @(negedge clk);
        a_cont = 1'b0;
        wait_valid_a(400, ok);
        chk("cont3_completes", ok, 1);
        chk("cont3_idx", a_idx, 1);
        chk("cont3_period", a_period, 140);
        repeat (6) @(negedge clk);
        chk("cont_end_busy", a_busy, 0);
        f0 = a_falls;
        repeat (300) @(negedge clk);
        chk("cont_end_no_frame", a_falls, f0);

        // Asynchronous reset while SCK is high during bit 7.
        start_a(4'b0001);
        v0 = a_valids;
        f0 = a_falls;
        repeat (73) @(negedge clk);
        chk("bit7_sck_high", a_sck, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_cs", a_cs, 1);
        chk("abort_sck", a_sck, 0);
        chk("abort_busy", a_busy, 0);
        chk("abort_valid", a_valid, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("abort_no_valid", a_valids, v0);
        chk("abort_no_frame", a_falls, f0);
        chk("abort_idle", a_busy, 0);
        chk("abort_data_cleared", a_data, 0);

        // Narrow, fast configuration: channels 5 and 7.
        @(negedge clk); b_mask = 8'b1010_0000; b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        chk("b_cs_low", b_cs, 0);
        b_mask = 8'b0000_0001;
        wait_valid_b(100, ok);
        chk("b_valid5", ok, 1);
        chk("b_idx5", b_idx, 5);
        chk("b_data5", b_data, 10'h2B7);
        chk("b_mosi5", b_word, 16'hA000);
        chk("b_done5", b_done, 0);
        wait_valid_b(100, ok);
        chk("b_valid7", ok, 1);
        chk("b_idx7", b_idx, 7);
        chk("b_data7", b_data, 10'h155);
        chk("b_mosi7", b_word, 16'hE000);
        chk("b_done7", b_done, 1);
        chk("b_period", b_period, 35);
        repeat (4) @(negedge clk);
        chk("b_idle", b_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_adc_scanner.md
SPI_ADC_SCANNER -- requirements
Module: spi_adc_scanner

Interface
REQ-001 Parameter DATA_W, default 12, conversion result width in bits.
REQ-002 Parameter N_CH, default 4, number of ADC channels scanned; ADDR_W = max(1, clog2(N_CH)).
REQ-003 Parameter FRAME_BITS, default 16, SCK cycles per CS-low frame; SHALL satisfy FRAME_BITS >= DATA_W + ADDR_W (elaboration error otherwise).
REQ-004 Parameter CLK_DIV, default 4, clk cycles per SCK half-period; SHALL be >= 1.
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  request one scan; sampled only in IDLE.
REQ-008 cont  in  1  continuous mode: rescan after last channel while high.
REQ-009 ch_mask  in  N_CH  channel enable; bit i enables channel i; latched at scan start.
REQ-010 MISO  in  1  serial data from ADC.
REQ-011 MOSI  out  1  serial command to ADC.
REQ-012 SCK  out  1  SPI clock, mode 0 (idle low).
REQ-013 CS  out  1  active-low chip select.
REQ-014 ch_data  out  DATA_W  last captured result.
REQ-015 ch_idx  out  ADDR_W  channel of ch_data.
REQ-016 data_valid  out  1  one-cycle pulse: new ch_data/ch_idx.
REQ-017 scan_done  out  1  one-cycle pulse with data_valid of the last enabled channel.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 States: IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP; every state except IDLE is timed by one divider counter.
REQ-020 IDLE: start=1 with ch_mask!=0 latches mask, selects lowest enabled channel, enters CS_SETUP on the same edge (CS low one cycle after start); start with mask=0 ignored.
REQ-021 CS_SETUP lasts CLK_DIV cycles, SCK low, MOSI = frame bit FRAME_BITS-1.
REQ-022 SHIFT: per bit, SCK low CLK_DIV cycles then high CLK_DIV cycles; MISO sampled on the edge driving SCK high; MOSI advances on the edge driving SCK low.
REQ-023 MOSI frame, MSB first: bits [FRAME_BITS-1 -: ADDR_W] = channel index, all remaining bits 0.
REQ-024 Result = last DATA_W MISO bits of the frame, MSB first; earlier bits discarded.
REQ-025 After bit 0 high phase, SCK low, enter CS_HOLD for CLK_DIV cycles, CS still low.
REQ-026 CS_HOLD exit edge: CS high, ch_data/ch_idx updated, data_valid=1 for one cycle; enter GAP.
REQ-027 GAP lasts CLK_DIV cycles (CS high); then next higher enabled channel -> CS_SETUP; if none: cont=1 -> relatch ch_mask, restart at lowest enabled (mask 0 -> IDLE); cont=0 -> IDLE.
REQ-028 Frame period = CLK_DIV*(2*FRAME_BITS+3) cycles CS-low-to-CS-low (140 at defaults).
REQ-029 start while busy ignored; ch_mask changes mid-scan ignored; cont deassert mid-scan finishes current scan.
REQ-030 ch_data/ch_idx hold between data_valid pulses.
REQ-031 N_CH=1: ch_idx constant 0, address field 1 bit = 0.

Reset
REQ-032 rst_n low, asynchronously and even mid-frame: state IDLE, CS=1, SCK=0, MOSI=0, ch_data=0, ch_idx=0, data_valid=0, scan_done=0, busy=0, counters and latched mask 0; no data_valid for an aborted frame.
REQ-033 After rst_n release, no activity until a qualifying start.

Structure
REQ-034 Package spi_adc_pkg holds the state enum and the ADDR_W computation function.
REQ-035 One sub-module spi_tick_gen: CLK_DIV counter producing half-period tick, restarted at each state entry.

Verification
REQ-036 Reset: rst_n=0 -> CS=1, SCK=0, MOSI=0, busy=0, ch_data=0.
REQ-037 Defaults, ch_mask=4'b0101, start pulse, ADC model returns 12'hA5C ch0, 12'h3F1 ch2 -> MOSI frames 16'h0000, 16'h8000; valid (0,A5C) then (2,3F1)+scan_done; 140 cycles between CS falls; busy then 0.
REQ-038 cont=1, mask=4'b1000 -> repeated ch3 frames every 140 cycles; cont=0 mid-frame -> that frame completes, then IDLE.
REQ-039 rst_n pulsed during SHIFT bit 7 -> CS high immediately, no data_valid, IDLE after release.
REQ-040 start with mask=0 -> busy stays 0; start pulse during a scan -> no extra frames.
REQ-041 DATA_W=10, N_CH=8, FRAME_BITS=16, CLK_DIV=1 -> 35-cycle frames, channel 5 MOSI 16'hA000, 10-bit results correct.
